// File: rtl/hub75_bcm_scanner_if.sv
// Framebuffer read port between the HUB75 scanner and the renderer.
// rd_data is returned exactly one cycle after rd_en.
interface hub75_bcm_scanner_if #(
  parameter int COLS       = 64,
  parameter int ROW_BITS   = 4,
  parameter int COLOR_BITS = 4
);
  localparam int COLW = (COLS > 1) ? $clog2(COLS) : 1;

  logic                    rd_en;
  logic [ROW_BITS-1:0]     rd_row;
  logic [COLW-1:0]         rd_col;
  logic [6*COLOR_BITS-1:0] rd_data;

  modport master (
    output rd_en, rd_row, rd_col,
    input  rd_data
  );

  modport slave (
    input  rd_en, rd_row, rd_col,
    output rd_data
  );
endinterface

// File: rtl/hub75_bcm_scanner.sv
// HUB75 BCM scan driver: framebuffer fetch, shift, latch, weighted display.
// Optional HUB75_BRIGHTNESS_EN adds a brightness input that shortens oe-low time.
module hub75_bcm_scanner #(
  parameter int COLS       = 64,
  parameter int ROW_BITS   = 4,
  parameter int COLOR_BITS = 4,
  parameter int OE_BASE    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]          brightness,
`endif
  hub75_bcm_scanner_if.master fb,
  output logic [ROW_BITS-1:0] row_addr,
  output logic                r0,
  output logic                g0,
  output logic                b0,
  output logic                r1,
  output logic                g1,
  output logic                b1,
  output logic                sclk,
  output logic                lat,
  output logic                oe,
  output logic                frame_done
);

  localparam int COLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SLEN = 2 * COLS + 2;
  localparam int DMAX = OE_BASE << (COLOR_BITS - 1);
  localparam int CMAX = (SLEN > DMAX) ? SLEN : DMAX;
  localparam int CNTW = $clog2(CMAX + 1);
  localparam int PW   = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
  localparam int DW   = 6 * COLOR_BITS;

  localparam logic [PW-1:0]       PLAST = PW'(COLOR_BITS - 1);
  localparam logic [ROW_BITS-1:0] RLAST = '1;
  localparam logic [CNTW-1:0]     SEND  = CNTW'(SLEN - 1);
  localparam logic [CNTW-1:0]     RDEND = CNTW'(2 * COLS);
  localparam logic [CNTW-1:0]     SCLK0 = CNTW'(3);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

  state_t              state, state_nx;
  logic [CNTW-1:0]     cnt, cnt_nx;
  logic [PW-1:0]       plane, plane_nx;
  logic [ROW_BITS-1:0] row, row_nx;
  logic [CNTW-1:0]     dlen, dlen_nx;
  logic [DW-1:0]       sh;
  logic [5:0]          rgb, rgb_nx;
  logic                rd_en_nx, sclk_nx, lat_nx, oe_nx, done_nx;
  logic [ROW_BITS-1:0] rd_row_nx, row_addr_nx;
  logic [COLW-1:0]     rd_col_nx;
`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0]          bright;
  logic [CNTW+8:0]     prod;
`endif

  assign dlen    = CNTW'(OE_BASE) << plane;
  assign dlen_nx = CNTW'(OE_BASE) << plane_nx;
  assign sh      = fb.rd_data >> plane;
  assign {r0, g0, b0, r1, g1, b1} = rgb;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    plane_nx = plane;
    row_nx   = row;
    unique case (state)
      IDLE: begin
        if (en) begin
          state_nx = SHIFT;
          cnt_nx   = '0;
        end
      end
      SHIFT: begin
        if (cnt == SEND) begin
          state_nx = LATCH;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      LATCH: begin
        state_nx = DISPLAY;
        cnt_nx   = '0;
      end
      DISPLAY: begin
        if (cnt == dlen - 1'b1) begin
          cnt_nx   = '0;
          plane_nx = '0;
          if (plane != PLAST) begin
            plane_nx = plane + 1'b1;
            state_nx = SHIFT;
          end else if (row != RLAST) begin
            row_nx   = row + 1'b1;
            state_nx = SHIFT;
          end else begin
            row_nx   = '0;
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next state.
  always_comb begin
    rd_en_nx    = state_nx == SHIFT && !cnt_nx[0] && cnt_nx < RDEND;
    rd_row_nx   = rd_en_nx ? row_nx : fb.rd_row;
    rd_col_nx   = rd_en_nx ? COLW'(cnt_nx >> 1) : fb.rd_col;
    sclk_nx     = state_nx == SHIFT && cnt_nx[0] && cnt_nx >= SCLK0;
    lat_nx      = state_nx == LATCH;
    row_addr_nx = lat_nx ? row_nx : row_addr;
    done_nx     = state_nx == DISPLAY && cnt_nx == dlen_nx - 1'b1 &&
                  plane_nx == PLAST && row_nx == RLAST;
    rgb_nx      = rgb;
    if (state == SHIFT && cnt[0] && cnt < RDEND)
      rgb_nx = {sh[5*COLOR_BITS], sh[4*COLOR_BITS], sh[3*COLOR_BITS],
                sh[2*COLOR_BITS], sh[COLOR_BITS], sh[0]};
`ifdef HUB75_BRIGHTNESS_EN
    prod  = (CNTW+9)'(dlen_nx) * (CNTW+9)'({1'b0, bright} + 9'd1);
    oe_nx = !(state_nx == DISPLAY && {1'b0, cnt_nx} < prod[CNTW+8:8]);
`else
    oe_nx = state_nx != DISPLAY;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      plane      <= '0;
      row        <= '0;
      fb.rd_en   <= 1'b0;
      fb.rd_row  <= '0;
      fb.rd_col  <= '0;
      row_addr   <= '0;
      rgb        <= '0;
      sclk       <= 1'b0;
      lat        <= 1'b0;
      oe         <= 1'b1;
      frame_done <= 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
      bright     <= '0;
`endif
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      plane      <= plane_nx;
      row        <= row_nx;
      fb.rd_en   <= rd_en_nx;
      fb.rd_row  <= rd_row_nx;
      fb.rd_col  <= rd_col_nx;
      row_addr   <= row_addr_nx;
      rgb        <= rgb_nx;
      sclk       <= sclk_nx;
      lat        <= lat_nx;
      oe         <= oe_nx;
      frame_done <= done_nx;
`ifdef HUB75_BRIGHTNESS_EN
      if (lat_nx)
        bright <= brightness;
`endif
    end
  end

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// Directed bench for hub75_bcm_scanner: cycle table, per-shift scoreboard,
// frame spacing, mid-shift reset and (with HUB75_BRIGHTNESS_EN) dimming.
module tb_hub75_bcm_scanner;
  localparam int COLS       = 4;
  localparam int ROW_BITS   = 2;
  localparam int COLOR_BITS = 2;
`ifdef HUB75_BRIGHTNESS_EN
  localparam int OE_BASE    = 16;
`else
  localparam int OE_BASE    = 2;
`endif
  localparam int ROWT  = COLOR_BITS * (2 * COLS + 3) + OE_BASE * 3;
  localparam int FRAME = 4 * ROWT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic [ROW_BITS-1:0] row_addr;
  logic r0, g0, b0, r1, g1, b1, sclk, lat, oe, frame_done;
`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0] brightness = 8'd255;
`endif

  always #5 clk = ~clk;

  hub75_bcm_scanner_if #(
    .COLS(COLS), .ROW_BITS(ROW_BITS), .COLOR_BITS(COLOR_BITS)
  ) fb ();

  hub75_bcm_scanner #(
    .COLS(COLS), .ROW_BITS(ROW_BITS),
    .COLOR_BITS(COLOR_BITS), .OE_BASE(OE_BASE)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .fb(fb), .row_addr(row_addr),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .sclk(sclk), .lat(lat), .oe(oe), .frame_done(frame_done)
  );

  function automatic logic [11:0] pix(input logic [1:0] r,
                                      input logic [1:0] c);
    logic [1:0] tr;
    tr = (c == 2'd1) ? 2'b10 : 2'b00;
    return {tr, c, r, ~c, r ^ c, 2'b01};
  endfunction

  always_ff @(posedge clk)
    if (fb.rd_en)
      fb.rd_data <= pix(fb.rd_row, fb.rd_col);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fd(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_done && n < limit);
  endtask

  function automatic logic [31:0] outs();
    return 32'({fb.rd_en, fb.rd_row, fb.rd_col, row_addr,
                r0, g0, b0, r1, g1, b1, sclk, lat, oe, frame_done});
  endfunction

  typedef struct {
    int         cyc;
    logic       rd_en;
    logic [1:0] col;
    logic       sclk;
    logic       lat;
    logic       oe;
    logic [1:0] ra;
    logic       fd;
  } vec_t;

  localparam int NV = 17;
  vec_t tab [NV];
  int   exp_on [COLOR_BITS];

  initial begin
    int n, n_lat, sidx, nrd, on_cnt, fd_at, rr, pp;
    logic [1:0]  prev_ra;
    logic [11:0] s;

    tab[0]  = '{1,   1, 0, 0, 0, 1, 0, 0};
    tab[1]  = '{2,   0, 0, 0, 0, 1, 0, 0};
    tab[2]  = '{4,   0, 1, 1, 0, 1, 0, 0};
    tab[3]  = '{5,   1, 2, 0, 0, 1, 0, 0};
    tab[4]  = '{7,   1, 3, 0, 0, 1, 0, 0};
    tab[5]  = '{10,  0, 3, 1, 0, 1, 0, 0};
    tab[6]  = '{11,  0, 3, 0, 1, 1, 0, 0};
    tab[7]  = '{12,  0, 3, 0, 0, 0, 0, 0};
    tab[8]  = '{13,  0, 3, 0, 0, 0, 0, 0};
    tab[9]  = '{14,  1, 0, 0, 0, 1, 0, 0};
    tab[10] = '{24,  0, 3, 0, 1, 1, 0, 0};
    tab[11] = '{28,  0, 3, 0, 0, 0, 0, 0};
    tab[12] = '{29,  1, 0, 0, 0, 1, 0, 0};
    tab[13] = '{39,  0, 3, 0, 1, 1, 1, 0};
    tab[14] = '{40,  0, 3, 0, 0, 0, 1, 0};
    tab[15] = '{112, 0, 3, 0, 0, 0, 3, 1};
    tab[16] = '{113, 0, 3, 0, 0, 1, 3, 0};
`ifdef HUB75_BRIGHTNESS_EN
    exp_on = '{8, 16};
`else
    exp_on = '{2, 4};
`endif

    rst = 1'b1;
    en  = 1'b0;
    repeat (3) step();
    chk("reset_outs", outs(), 32'h2);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("idle%0d", i),
          32'({fb.rd_en, sclk, lat, oe, frame_done}), 32'h2);
    end

`ifdef HUB75_BRIGHTNESS_EN
    brightness = 8'd127;
`endif
    en = 1'b1;
    step();
    en = 1'b0;
    n_lat = 0; sidx = 0; nrd = 0; on_cnt = 0; fd_at = 0;
    prev_ra = '0;
    for (int c = 1; c <= FRAME + 1; c++) begin
      if (c > 1) step();
`ifndef HUB75_BRIGHTNESS_EN
      for (int i = 0; i < NV; i++)
        if (tab[i].cyc == c)
          chk($sformatf("vec@%0d", c),
              32'({fb.rd_en, fb.rd_en ? fb.rd_col : 2'b00,
                   sclk, lat, oe, row_addr, frame_done}),
              32'({tab[i].rd_en, tab[i].rd_en ? tab[i].col : 2'b00,
                   tab[i].sclk, tab[i].lat, tab[i].oe,
                   tab[i].ra, tab[i].fd}));
`endif
      rr = n_lat / COLOR_BITS;
      pp = n_lat % COLOR_BITS;
      if (fb.rd_en) begin
        chk("rd_row", 32'(fb.rd_row), 32'(rr));
        chk("rd_col", 32'(fb.rd_col), 32'(nrd));
        nrd++;
      end
      if (sclk) begin
        s = pix(2'(rr), 2'(sidx)) >> pp;
        chk($sformatf("colour r%0d p%0d c%0d", rr, pp, sidx),
            32'({r0, g0, b0, r1, g1, b1}),
            32'({s[10], s[8], s[6], s[4], s[2], s[0]}));
        if (sidx == 1)
          chk($sformatf("r0_col1 p%0d", pp), 32'(r0), 32'(pp));
        sidx++;
      end
      if (!oe) on_cnt++;
      if (row_addr != prev_ra) begin
        chk("ra_blank", 32'({lat, oe}), 32'h3);
        chk("ra_step", 32'(row_addr), 32'(prev_ra) + 1);
        prev_ra = row_addr;
      end
      if (lat) begin
        chk("sclk_per_shift", 32'(sidx), 32'(COLS));
        chk("rd_per_shift", 32'(nrd), 32'(COLS));
        if (n_lat > 0)
          chk("on_time", 32'(on_cnt), 32'(exp_on[(n_lat-1) % COLOR_BITS]));
        on_cnt = 0; sidx = 0; nrd = 0;
        n_lat++;
      end
      if (frame_done) fd_at = c;
    end
    chk("on_time_last", 32'(on_cnt), 32'(exp_on[COLOR_BITS-1]));
    chk("latch_count", 32'(n_lat), 32'(4 * COLOR_BITS));
    chk("fd_cycle", 32'(fd_at), 32'(FRAME));
    chk("ra_final", 32'(prev_ra), 32'h3);

    en = 1'b1;
    wait_fd(3 * FRAME, n);
    chk("fd_first", 32'(frame_done), 32'h1);
    wait_fd(3 * FRAME, n);
    chk("fd_spacing", 32'(n), 32'(FRAME + 1));

    repeat (3) step();
    chk("mid_shift_busy", 32'(oe), 32'h1);
    rst = 1'b1;
    step();
    chk("rst_mid", outs(), 32'h2);
    rst = 1'b0;
    step();
    en = 1'b0;
    chk("restart", 32'({fb.rd_en, fb.rd_row, fb.rd_col, oe}), 32'h21);
    wait_fd(3 * FRAME, n);
    chk("restart_fd", 32'(n), 32'(FRAME - 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hub75_bcm_scanner.md
Name: hub75_bcm_scanner

Overview:
- Parametrised next-generation HUB75 scan driver for the rhythm-game LED panel.
- Replaces single-bit-per-colour map slicing with a framebuffer read port, and adds binary-code-modulated (BCM) colour depth.
- Also adds an explicit shift clock, a configurable panel width and a configurable scan depth.
- Sits between the game's framebuffer/renderer and the panel pins. Each scan step drives two half-panel rows: top half and bottom half.

Parameters:
- COLS, 64: pixels per row shifted per scan step.
- ROW_BITS, 4: row-address width. Scan rows = 2**ROW_BITS.
- COLOR_BITS, 4: bit planes per colour channel.
- OE_BASE, 8: display cycles for bit plane 0. Plane p displays OE_BASE<<p cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  start/continue scanning. Sampled only in IDLE.
- rd_en  out  1  framebuffer read strobe.
- rd_row  out  ROW_BITS  row being fetched.
- rd_col  out  clog2(COLS)  column being fetched.
- rd_data  in  6*COLOR_BITS  {top R,G,B, bottom R,G,B}, each COLOR_BITS wide. Valid exactly 1 cycle after rd_en.
- row_addr  out  ROW_BITS  panel A/B/C/D… address.
- r0,g0,b0,r1,g1,b1  out  1 each  serial colour data, top/bottom.
- sclk  out  1  panel shift clock.
- lat  out  1  panel latch.
- oe  out  1  output enable, 1 = blanked.
- frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- All outputs are registered.
- Reset values: oe=1, and every other output 0. Internal row, plane and column counters are 0. State is IDLE.
- rst mid-operation: reset values take effect on the next edge regardless of state.
- States are IDLE, SHIFT, LATCH and DISPLAY.
- IDLE:
  - oe=1.
  - Goes to SHIFT when en=1. Otherwise stays in IDLE.
- SHIFT (plane p, row r) lasts exactly 2*COLS+2 cycles, numbered t=0…2*COLS+1.
  - Even t=2k (k<COLS): rd_en=1, rd_row=r, rd_col=k.
  - Odd t=2k+1: colour regs capture bit p of rd_data fields. Example: r0 <= top_R[p].
  - sclk=1 on odd t≥3; otherwise sclk=0. Data is therefore stable a full cycle before each rising sclk.
  - Exactly COLS sclk pulses occur. oe=1 throughout.
- LATCH lasts 1 cycle.
  - lat=1 and oe=1.
  - row_addr is updated to r in this cycle, so the address changes only while blanked.
- DISPLAY lasts OE_BASE<<p cycles with oe=0 and lat=0. At its end:
  - If p<COLOR_BITS-1: p++ and go to SHIFT with the same r.
  - Else if r<2**ROW_BITS-1: set p=0, r++ and go to SHIFT.
  - Else (r wraps to 0): frame_done=1 in the final DISPLAY cycle, then go to IDLE.
- en deasserted mid-frame has no effect until the frame completes.
- en held high gives back-to-back frames with exactly 1 IDLE cycle between them.
- Row time = COLOR_BITS*(2*COLS+3) + OE_BASE*(2**COLOR_BITS-1) cycles.
- Counter widths must hold OE_BASE<<(COLOR_BITS-1) without overflow.

Optional Feature:
- Macro: HUB75_BRIGHTNESS_EN.
- When defined:
  - Adds input port brightness [7:0].
  - Brightness is sampled at LATCH entry.
  - In DISPLAY, oe=0 only for the first ((OE_BASE<<p)*(brightness+1))>>8 cycles, and oe=1 for the remaining cycles.
  - DISPLAY length is unchanged, so frame timing is identical.
  - brightness=255 is equivalent to the undefined build. brightness=0 keeps OE_BASE<<p<256 planes fully dark.
- When undefined: no brightness port, and oe=0 for the whole of DISPLAY.

Test Plan (COLS=4, ROW_BITS=2, COLOR_BITS=2, OE_BASE=2 unless stated):
- Reset, then en=0 for 20 cycles → oe=1, and lat, sclk, rd_en and frame_done all stay 0.
- en=1 pulsed once → SHIFT is 10 cycles with 4 rd_en pulses (cols 0..3) and 4 sclk pulses. LATCH is 1 cycle. DISPLAY is 2 then 4 cycles. Row period is 28 cycles and frame_done arrives at cycle 112 after leaving IDLE.
- rd_data model returns top_R=2'b10 for col 1 only → r0=0 at plane 0 and r0=1 at plane 1, sampled on the second sclk rise.
- Check row_addr across a frame → sequence 0,1,2,3. Each change coincides with lat=1 and oe=1. row_addr never changes while oe=0.
- Hold en=1 → frame_done is spaced 113 cycles apart. Assert rst mid-SHIFT → next cycle all outputs at reset values, and scanning restarts from row 0 plane 0.
- HUB75_BRIGHTNESS_EN with OE_BASE=16 and brightness=127 → plane 0 has oe low for 8 of 16 cycles, plane 1 for 16 of 32 cycles.
